dvp_frame_capture: RTL and testbench

- Parametrised DVP camera capture front end, successor to the fixed OV7725 capture path feeding cnn_top.
- Samples the sensor byte bus (data/href/vsync) on the pixel clock and assembles BYTES_PER_PIX-byte pixels (MSB first).
- Discards sensor settle frames, crops a runtime-programmable window, and emits a pixel stream with frame/line markers to the CNN/LCD pipeline.
- Reports frame count and line-length errors.

---
 rtl/dvp_frame_capture.sv | 243 ++++++++++++++++++++++++
 tb/tb_dvp_frame_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_capture.sv
// DVP camera capture front end.
// Assembles sensor bytes into pixels, crops a window, flags frame/line events.
module dvp_frame_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int SKIP_FRAMES   = 10,
  parameter int CNT_W         = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_href,
  input  logic                            i_vsync,
  input  logic                            i_cap_en,
  input  logic [CNT_W-1:0]                i_win_x0,
  input  logic [CNT_W-1:0]                i_win_y0,
  input  logic [CNT_W-1:0]                i_win_w,
  input  logic [CNT_W-1:0]                i_win_h,
  output logic [DATA_W*BYTES_PER_PIX-1:0] o_pix,
  output logic                            o_pix_vld,
  output logic                            o_sof,
  output logic                            o_eol,
  output logic                            o_eof,
  output logic [15:0]                     o_frame_cnt,
  output logic                            o_line_err,
  output logic                            o_busy
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam int IDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIX - 1);
  localparam logic [CNT_W-1:0] H_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END = CNT_W'(V_ACTIVE);
  localparam logic [15:0] SKIP_LD = 16'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE, S_SKIP, S_WAIT, S_ACTIVE
  } state_t;

  state_t state_q, state_d;
  logic [15:0] skip_q, skip_d;
  logic vsync_q, href_q, frm_q, frm_d;
  logic fs_pend_q, fs_pend_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_cur;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, y_fe;
  logic [CNT_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [CNT_W-1:0] xe_q, xe_d, ye_q, ye_d;
  logic [PIX_W-1:0] pix_q, pix_d, pix_new;
  logic vld_q, vld_d, sof_q, sof_d;
  logic eol_q, eol_d, eof_q, eof_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic fs, fe, h, h_rise, line_end;
  logic act, go_act, pix_done, in_win, shift;

  function automatic logic [CNT_W-1:0] win_end(
    input logic [CNT_W-1:0] org,
    input logic [CNT_W-1:0] len,
    input logic [CNT_W-1:0] lim
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, org} + {1'b0, len};
    if (len == '0 || sum >= {1'b0, lim}) return lim;
    return sum[CNT_W-1:0];
  endfunction

  // href is forced low on frame end so a line still open at vsync rise closes first
  assign fs       = vsync_q & ~i_vsync;
  assign fe       = ~vsync_q & i_vsync;
  assign h        = i_href & ~fe;
  assign h_rise   = h & ~href_q;
  assign line_end = href_q & ~h;
  assign act      = (state_q == S_ACTIVE);
  assign idx_cur  = h_rise ? '0 : idx_q;
  assign shift    = act & h;
  assign pix_done = shift && (idx_cur == LAST_IDX);
  assign in_win   = (x_q >= x0_q) && (x_q < xe_q) &&
                    (y_q >= y0_q) && (y_q < ye_q);
  assign y_fe     = line_end ? y_q + 1'b1 : y_q;
  assign frm_d    = fs ? 1'b1 : (fe ? 1'b0 : frm_q);

  generate
    if (BYTES_PER_PIX == 1) begin : g_one
      assign pix_new = i_data;
    end else begin : g_multi
      localparam int SR_W = PIX_W - DATA_W;
      logic [SR_W-1:0] sr_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else if (shift) sr_q <= pix_new[SR_W-1:0];
      end
      assign pix_new = {sr_q, i_data};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    fs_pend_d = 1'b0;
    go_act    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        skip_d = SKIP_LD;
        if (i_cap_en)
          state_d = (SKIP_FRAMES > 0) ? S_SKIP : S_WAIT;
      end
      S_SKIP: begin
        if (!i_cap_en) begin
          state_d = S_IDLE;
          skip_d  = SKIP_LD;
        end else if (fe && frm_q) begin
          // only frames whose start was seen count as settled
          skip_d = skip_q - 16'd1;
          if (skip_q <= 16'd1) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_cap_en) begin
          state_d = S_IDLE;
          skip_d  = SKIP_LD;
        end else if ((fs || fs_pend_q) && !i_href) begin
          state_d = S_ACTIVE;
          go_act  = 1'b1;
        end else begin
          fs_pend_d = (fs || fs_pend_q) && !fe;
        end
      end
      S_ACTIVE: begin
        if (fe) state_d = i_cap_en ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    x0_d  = x0_q;
    y0_d  = y0_q;
    xe_d  = xe_q;
    ye_d  = ye_q;
    pix_d = pix_q;
    vld_d = 1'b0;
    sof_d = 1'b0;
    eol_d = 1'b0;
    eof_d = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    if (go_act) begin
      idx_d = '0;
      x_d   = '0;
      y_d   = '0;
      err_d = 1'b0;
      x0_d  = i_win_x0;
      y0_d  = i_win_y0;
      xe_d  = win_end(i_win_x0, i_win_w, H_END);
      ye_d  = win_end(i_win_y0, i_win_h, V_END);
    end
    if (act) begin
      if (h) begin
        idx_d = pix_done ? '0 : idx_cur + 1'b1;
        if (pix_done) begin
          if (x_q != '1) x_d = x_q + 1'b1;
          if (in_win) begin
            pix_d = pix_new;
            vld_d = 1'b1;
            sof_d = (x_q == x0_q) && (y_q == y0_q);
            eol_d = (x_q == xe_q - 1'b1);
            eof_d = (x_q == xe_q - 1'b1) && (y_q == ye_q - 1'b1);
          end
        end
      end
      if (line_end) begin
        x_d = '0;
        if (y_q != '1) y_d = y_q + 1'b1;
        if (idx_q != '0 || x_q != H_END) err_d = 1'b1;
      end
      if (fe) begin
        cnt_d = cnt_q + 16'd1;
        if (y_fe != V_END) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      skip_q    <= SKIP_LD;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      frm_q     <= 1'b0;
      fs_pend_q <= 1'b0;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      pix_q     <= '0;
      vld_q     <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      vsync_q   <= i_vsync;
      href_q    <= i_href;
      frm_q     <= frm_d;
      fs_pend_q <= fs_pend_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      pix_q     <= pix_d;
      vld_q     <= vld_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign o_pix       = pix_q;
  assign o_pix_vld   = vld_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;
  assign o_eof       = eof_q;
  assign o_frame_cnt = cnt_q;
  assign o_line_err  = err_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Directed bench for dvp_frame_capture with a pixel scoreboard.
// Two instances: 2-byte pixels (main) and 1-byte pixels.
module tb_dvp_frame_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic clk, rst;
  logic [7:0] data;
  logic href, vsync, cap_en0, cap_en1;
  logic [11:0] wx0, wy0, ww, wh;

  logic [15:0] pix0, cnt0, cnt1;
  logic [7:0] pix1;
  logic pv0, sof0, eol0, eof0, err0, busy0;
  logic pv1, sof1, eol1, eof1, err1, busy1;

  typedef struct {
    logic [15:0] pix;
    logic sof, eol, eof;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int fails = 0;

  dvp_frame_capture #(
    .DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(H), .V_ACTIVE(V),
    .SKIP_FRAMES(1), .CNT_W(12)
  ) u0 (
    .clk(clk), .rst(rst), .i_data(data), .i_href(href),
    .i_vsync(vsync), .i_cap_en(cap_en0),
    .i_win_x0(wx0), .i_win_y0(wy0), .i_win_w(ww), .i_win_h(wh),
    .o_pix(pix0), .o_pix_vld(pv0), .o_sof(sof0), .o_eol(eol0),
    .o_eof(eof0), .o_frame_cnt(cnt0), .o_line_err(err0),
    .o_busy(busy0)
  );

  dvp_frame_capture #(
    .DATA_W(8), .BYTES_PER_PIX(1), .H_ACTIVE(H), .V_ACTIVE(V),
    .SKIP_FRAMES(1), .CNT_W(12)
  ) u1 (
    .clk(clk), .rst(rst), .i_data(data), .i_href(href),
    .i_vsync(vsync), .i_cap_en(cap_en1),
    .i_win_x0(wx0), .i_win_y0(wy0), .i_win_w(ww), .i_win_h(wh),
    .o_pix(pix1), .o_pix_vld(pv1), .o_sof(sof1), .o_eol(eol1),
    .o_eof(eof1), .o_frame_cnt(cnt1), .o_line_err(err1),
    .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pv0) begin
      chk("pix0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("pix0", pix0, e0.pix);
        chk("sof0", sof0, e0.sof);
        chk("eol0", eol0, e0.eol);
        chk("eof0", eof0, e0.eof);
        chk("lat0", cyc, e0.cyc);
      end
    end
    if (pv1) begin
      chk("pix1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("pix1", pix1, e1.pix);
        chk("sof1", sof1, e1.sof);
        chk("eol1", eol1, e1.eol);
        chk("eof1", eof1, e1.eof);
        chk("lat1", cyc, e1.cyc);
      end
    end
  end

  // p0/p1: push expectations for u0/u1; drop_ln: cap_en0 falls
  // at that line; rst_b: async reset before that frame byte
  task automatic send_frame(input int nl, input int nb,
                            input int bad_ln, input int bad_nb,
                            input bit p0, input bit p1,
                            input int drop_ln, input int rst_b);
    int bv, n, x, xe, ye;
    logic [7:0] prev;
    bit inw;
    bv = 0;
    prev = 8'h00;
    xe = (ww == 0) ? H : ((int'(wx0) + int'(ww) > H) ? H : int'(wx0) + int'(ww));
    ye = (wh == 0) ? V : ((int'(wy0) + int'(wh) > V) ? V : int'(wy0) + int'(wh));
    repeat (4) begin
      @(posedge clk); #1;
      vsync = 1'b1;
      href = 1'b0;
    end
    @(posedge clk); #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    for (int ln = 0; ln < nl; ln++) begin
      n = (ln == bad_ln) ? bad_nb : nb;
      for (int bi = 0; bi < n; bi++) begin
        if (bv == rst_b) begin
          @(posedge clk);
          @(negedge clk);
          #1 rst = 1'b1;
          #1;
          chk("rst_vld", pv0, 0);
          chk("rst_pix", pix0, 0);
          chk("rst_cnt", cnt0, 0);
          chk("rst_err", err0, 0);
          chk("rst_busy", busy0, 0);
          chk("rst_mark", {sof0, eol0, eof0}, 0);
          chk("rst_drained", q0.size(), 0);
          @(posedge clk); #1 rst = 1'b0;
          p0 = 1'b0;
          p1 = 1'b0;
        end
        @(posedge clk); #1;
        if (bi == 0 && ln == drop_ln) cap_en0 = 1'b0;
        href = 1'b1;
        data = bv[7:0];
        if (p0 && (bi % 2 == 1)) begin
          x = bi / 2;
          inw = x < H && ln < V && x >= int'(wx0) && x < xe &&
                ln >= int'(wy0) && ln < ye;
          if (inw)
            q0.push_back('{ {prev, data}, x == int'(wx0) && ln == int'(wy0),
                            x == xe - 1, x == xe - 1 && ln == ye - 1,
                            cyc + 1 });
        end
        if (p1) begin
          x = bi;
          inw = x < H && ln < V && x >= int'(wx0) && x < xe &&
                ln >= int'(wy0) && ln < ye;
          if (inw)
            q1.push_back('{ {8'h00, data}, x == int'(wx0) && ln == int'(wy0),
                            x == xe - 1, x == xe - 1 && ln == ye - 1,
                            cyc + 1 });
        end
        prev = data;
        bv++;
      end
      repeat (3) begin
        @(posedge clk); #1 href = 1'b0;
      end
      if (ln == 0 && p0) chk("err_cleared", err0, 0);
    end
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
  endtask

  task automatic set_win(input int x0, input int y0,
                         input int w, input int hh);
    wx0 = 12'(x0);
    wy0 = 12'(y0);
    ww  = 12'(w);
    wh  = 12'(hh);
  endtask

  initial begin
    rst = 1'b1;
    vsync = 1'b1;
    href = 1'b0;
    data = 8'h00;
    cap_en0 = 1'b0;
    cap_en1 = 1'b0;
    set_win(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vld", pv0, 0);
    chk("reset_pix", pix0, 0);
    chk("reset_cnt", cnt0, 0);
    chk("reset_err", err0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_mark", {sof0, eol0, eof0}, 0);
    rst = 1'b0;
    @(posedge clk); #1 cap_en0 = 1'b1;
    @(posedge clk); #1;
    chk("busy_skip", busy0, 1);

    send_frame(4, 16, -1, 0, 0, 0, -1, -1);
    chk("skip_cnt", cnt0, 0);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("full_cnt", cnt0, 1);
    chk("full_err", err0, 0);

    set_win(2, 1, 3, 2);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("win_cnt", cnt0, 2);

    set_win(6, 0, 5, 0);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("clip_cnt", cnt0, 3);
    set_win(9, 0, 0, 0);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("offwin_cnt", cnt0, 4);

    set_win(0, 0, 0, 0);
    send_frame(4, 16, 2, 15, 1, 0, -1, -1);
    chk("odd_cnt", cnt0, 5);
    chk("odd_err", err0, 1);
    send_frame(3, 16, -1, 0, 1, 0, -1, -1);
    chk("short_cnt", cnt0, 6);
    chk("short_err", err0, 1);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("good_err", err0, 0);

    send_frame(4, 16, -1, 0, 1, 0, 1, -1);
    chk("drop_cnt", cnt0, 8);
    chk("drop_busy", busy0, 0);
    cap_en0 = 1'b1;
    send_frame(4, 16, -1, 0, 0, 0, -1, -1);
    chk("reskip_cnt", cnt0, 8);
    chk("reskip_busy", busy0, 1);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("recap_cnt", cnt0, 9);

    send_frame(4, 16, -1, 0, 1, 0, -1, 20);
    chk("post_rst_cnt", cnt0, 0);
    chk("post_rst_busy", busy0, 1);
    send_frame(4, 16, -1, 0, 0, 0, -1, -1);
    chk("post_rst_skip", cnt0, 0);
    send_frame(4, 16, -1, 0, 1, 0, -1, -1);
    chk("post_rst_cap", cnt0, 1);

    cap_en0 = 1'b0;
    cap_en1 = 1'b1;
    send_frame(4, 8, -1, 0, 0, 0, -1, -1);
    chk("b1_skip_cnt", cnt1, 0);
    send_frame(4, 8, -1, 0, 0, 1, -1, -1);
    chk("b1_cnt", cnt1, 1);
    chk("b1_err", err1, 0);
    chk("b1_u0_idle", busy0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
